// File: rtl/report_collector.sv
// Tags non-zero report vectors with their symbol offset and queues them in a FWFT FIFO.
// Optional end-of-stream marker records are built when RPT_EOS_MARKER_EN is defined.
module report_collector #(
  parameter int unsigned NUM_REPORTS  = 8,
  parameter int unsigned OFFSET_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned DROP_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [NUM_REPORTS-1:0]  report_vec,
  output logic                    rpt_valid,
  input  logic                    rpt_ready,
  output logic [OFFSET_WIDTH-1:0] rpt_offset,
  output logic [NUM_REPORTS-1:0]  rpt_vector,
  output logic                    rpt_eos,
  output logic                    overflow,
  output logic [DROP_WIDTH-1:0]   drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef RPT_EOS_MARKER_EN
  localparam int unsigned EW = OFFSET_WIDTH + NUM_REPORTS + 1;
`else
  localparam int unsigned EW = OFFSET_WIDTH + NUM_REPORTS;
`endif

  logic [OFFSET_WIDTH-1:0] r_offset;
  logic [OFFSET_WIDTH-1:0] r_offset_q;
  logic                    r_run_q;
  logic [EW-1:0]           r_mem [FIFO_DEPTH];
  logic [AW:0]             r_wr_ptr;
  logic [AW:0]             r_rd_ptr;
  logic [EW-1:0]           r_head;
  logic                    r_overflow;
  logic [DROP_WIDTH-1:0]   r_drop_count;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_room;
  logic          w_rep;
  logic          w_rep_push;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_wdata;
  logic [AW:0]   w_next_wr;
  logic [AW:0]   w_next_rd;
  logic [EW-1:0] w_next_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && rpt_ready;
  assign w_room  = !w_full || w_pop;
  assign w_rep   = r_run_q && (report_vec != '0);

`ifdef RPT_EOS_MARKER_EN
  logic                    r_eos_pend;
  logic [OFFSET_WIDTH-1:0] r_eos_off;
  logic                    w_fall;
  logic                    w_mark_push;

  assign w_fall      = r_run_q && !run;
  // A waiting marker owns the single write slot; a same-cycle report loses it.
  assign w_mark_push = r_eos_pend && w_room;
  assign w_rep_push  = w_rep && w_room && !w_mark_push;
  assign w_push      = w_rep_push || w_mark_push;
  assign w_wdata     = w_mark_push ? {1'b1, r_eos_off, {NUM_REPORTS{1'b0}}}
                                   : {1'b0, r_offset_q, report_vec};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_eos_pend <= 1'b0;
      r_eos_off  <= '0;
    end else begin
      if (w_fall) begin
        r_eos_pend <= 1'b1;
        r_eos_off  <= r_offset;
      end else if (w_mark_push) begin
        r_eos_pend <= 1'b0;
      end
    end
  end

  assign rpt_eos = r_head[EW-1];
`else
  assign w_rep_push = w_rep && w_room;
  assign w_push     = w_rep_push;
  assign w_wdata    = {r_offset_q, report_vec};
  assign rpt_eos    = 1'b0;
`endif

  assign w_drop    = w_rep && !w_rep_push;
  assign w_next_wr = r_wr_ptr + (AW + 1)'(w_push);
  assign w_next_rd = r_rd_ptr + (AW + 1)'(w_pop);

  // Head is registered from the post-edge read slot, bypassing a write into that same slot.
  always_comb begin
    w_next_head = r_mem[w_next_rd[AW-1:0]];
    if (w_push && (w_next_rd[AW-1:0] == r_wr_ptr[AW-1:0])) begin
      w_next_head = w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_offset     <= '0;
      r_offset_q   <= '0;
      r_run_q      <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_head       <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_run_q    <= run;
      r_offset_q <= r_offset;
      if (run) begin
        r_offset <= r_offset + 1'b1;
      end
      r_wr_ptr <= w_next_wr;
      r_rd_ptr <= w_next_rd;
      if (w_next_wr != w_next_rd) begin
        r_head <= w_next_head;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + 1'b1;
        end
      end
    end
  end

  assign rpt_valid  = !w_empty;
  assign rpt_offset = r_head[NUM_REPORTS +: OFFSET_WIDTH];
  assign rpt_vector = r_head[NUM_REPORTS-1:0];
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_report_collector.sv
// Bench for report_collector: vector table, directed corner sequences, randomized run vs queue model.
module tb_report_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  report_vec = '0;
  logic        rpt_ready = 1'b0;
  logic        rpt_valid;
  logic [31:0] rpt_offset;
  logic [7:0]  rpt_vector;
  logic        rpt_eos;
  logic        overflow;
  logic [15:0] drop_count;

  logic        reset2 = 1'b1;
  logic        run2 = 1'b0;
  logic [7:0]  report_vec2 = '0;
  logic        rpt_valid2;
  logic [3:0]  rpt_offset2;
  logic [7:0]  rpt_vector2;
  logic        rpt_eos2;
  logic        overflow2;
  logic [15:0] drop_count2;

  always #5 clk = ~clk;

  report_collector dut (
    .clk(clk), .reset(reset), .run(run), .report_vec(report_vec),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_offset(rpt_offset),
    .rpt_vector(rpt_vector), .rpt_eos(rpt_eos), .overflow(overflow), .drop_count(drop_count)
  );

  report_collector #(.OFFSET_WIDTH(4)) dut_wrap (
    .clk(clk), .reset(reset2), .run(run2), .report_vec(report_vec2),
    .rpt_valid(rpt_valid2), .rpt_ready(1'b1), .rpt_offset(rpt_offset2),
    .rpt_vector(rpt_vector2), .rpt_eos(rpt_eos2), .overflow(overflow2), .drop_count(drop_count2)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct packed {
    logic [31:0] off;
    logic [7:0]  vec;
    logic        eos;
  } rec_t;

  rec_t        mq[$];
  logic [31:0] m_sym;
  logic [31:0] m_last_off;
  logic        m_last_run;
  logic [15:0] m_drops;
  logic        m_ovf;
  logic        m_pend;
  logic [31:0] m_pend_off;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Queue-level reference: pop, then at most one push into the freed room, else a drop.
  task automatic model_edge(input logic rst_i, input logic run_i, input logic [7:0] vec_i,
                            input logic ready_i);
    rec_t r;
    logic marked;
    if (rst_i) begin
      mq.delete();
      m_sym = 0; m_last_off = 0; m_last_run = 0; m_drops = 0; m_ovf = 0;
      m_pend = 0; m_pend_off = 0;
      return;
    end
    if (mq.size() > 0 && ready_i) mq.delete(0);
    marked = 1'b0;
`ifdef RPT_EOS_MARKER_EN
    if (m_pend && mq.size() < 16) begin
      r.off = m_pend_off; r.vec = 8'h00; r.eos = 1'b1;
      mq.push_back(r);
      m_pend = 1'b0;
      marked = 1'b1;
    end
`endif
    if (m_last_run && vec_i != 8'h00) begin
      if (!marked && mq.size() < 16) begin
        r.off = m_last_off; r.vec = vec_i; r.eos = 1'b0;
        mq.push_back(r);
      end else begin
        m_ovf = 1'b1;
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
      end
    end
`ifdef RPT_EOS_MARKER_EN
    if (m_last_run && !run_i) begin
      m_pend = 1'b1;
      m_pend_off = m_sym;
    end
`endif
    m_last_off = m_sym;
    m_last_run = run_i;
    if (run_i) m_sym = m_sym + 32'd1;
  endtask

  task automatic step(input logic rst_i, input logic run_i, input logic [7:0] vec_i,
                      input logic ready_i);
    reset = rst_i; run = run_i; report_vec = vec_i; rpt_ready = ready_i;
    @(posedge clk);
    model_edge(rst_i, run_i, vec_i, ready_i);
    #1;
    chk("valid", {31'd0, rpt_valid}, {31'd0, mq.size() > 0});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("drop_count", {16'd0, drop_count}, {16'd0, m_drops});
    if (mq.size() > 0 && rpt_valid) begin
      chk("head_offset", rpt_offset, mq[0].off);
      chk("head_vector", {24'd0, rpt_vector}, {24'd0, mq[0].vec});
      chk("head_eos", {31'd0, rpt_eos}, {31'd0, mq[0].eos});
    end
  endtask

  typedef struct {
    logic        rst;
    logic        run;
    logic [7:0]  vec;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_off;
    logic [7:0]  exp_vec;
  } vrow_t;

  vrow_t tbl[14];
  int unsigned got[$];
  int unsigned cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_edge(1'b1, 1'b0, 8'h00, 1'b0);

    // Single hit on symbol 3, then run gaps (1,0,1,1) with hits on every symbol.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'd0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'd0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'd0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'd0, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'd0, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 32'd3, 8'h01};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'd0, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 32'd0, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 32'd0, 8'h11};
    tbl[10] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 32'd0, 8'h11};
    tbl[11] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 32'd1, 8'h33};
    tbl[12] = '{1'b0, 1'b0, 8'h44, 1'b1, 1'b1, 32'd2, 8'h44};
    tbl[13] = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 32'd0, 8'h00};

`ifndef RPT_EOS_MARKER_EN
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].run, tbl[i].vec, tbl[i].rdy);
      chk("tbl_valid", {31'd0, rpt_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid || tbl[i].rst) begin
        chk("tbl_offset", rpt_offset, tbl[i].exp_off);
        chk("tbl_vector", {24'd0, rpt_vector}, {24'd0, tbl[i].exp_vec});
      end
      chk("tbl_drop", {16'd0, drop_count}, 32'd0);
    end
`endif

    // Back-pressure: 16 hits fill the FIFO, the 17th is dropped.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 18; k++) step(1'b0, k < 17, (k >= 1) ? 8'h01 : 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
    chk("bp_drop", {16'd0, drop_count}, 32'd1);
    chk("bp_valid", {31'd0, rpt_valid}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 12; i++) begin
      if (rpt_valid && !rpt_eos) begin
        chk("bp_drain_order", rpt_offset, cnt);
        cnt++;
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("bp_drained", cnt, 32'd12);

    // Reset with records still queued.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_valid", {31'd0, rpt_valid}, 32'd0);
    chk("rst_offset", rpt_offset, 32'd0);
    chk("rst_vector", {24'd0, rpt_vector}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);

    // Full FIFO with a simultaneous pop and push.
    for (int k = 0; k < 17; k++) step(1'b0, 1'b1, (k >= 1) ? 8'h01 : 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b1);
    chk("fp_drop", {16'd0, drop_count}, 32'd0);
    chk("fp_overflow", {31'd0, overflow}, 32'd0);
    got.delete();
    for (int i = 0; i < 40; i++) begin
      if (!rpt_valid) break;
      if (!rpt_eos) got.push_back(rpt_offset);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("fp_count", got.size(), 32'd16);
    if (got.size() == 16) begin
      chk("fp_first", got[0], 32'd1);
      chk("fp_last", got[15], 32'd16);
    end

`ifdef RPT_EOS_MARKER_EN
    // Three hitting symbols then run low: marker with the total count comes last.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0);
    step(1'b0, 1'b0, 8'h04, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("eos_valid", {31'd0, rpt_valid}, 32'd1);
      chk("eos_offset", rpt_offset, i);
      chk("eos_flag", {31'd0, rpt_eos}, (i == 3) ? 32'd1 : 32'd0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("eos_empty", {31'd0, rpt_valid}, 32'd0);
`endif

    // Offset wrap on the 4-bit instance; main instance is held in reset meanwhile.
    got.delete();
    reset2 = 1'b1;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    reset2 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      run2 = (k < 18);
      report_vec2 = (k >= 1 && k <= 18) ? 8'h80 : 8'h00;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      if (rpt_valid2 && !rpt_eos2) got.push_back({28'd0, rpt_offset2});
    end
    chk("wrap_count", got.size(), 32'd18);
    if (got.size() == 18) begin
      for (int i = 0; i < 18; i++) chk("wrap_offset", got[i], i % 16);
    end

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 400) == 0, ($urandom % 10) < 7,
           (($urandom % 2) == 0) ? 8'($urandom) : 8'h00, ($urandom % 10) < 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
